hazard_scoreboard: RTL and testbench

Parametrised Tuse/Tnew stall unit for the decode stage of the pipelined MIPS core, replacing fixed per-instruction-class comparator terms with a per-register countdown scoreboard. Each issued write records cycles-until-forwardable for its destination, and a decode instruction stalls while any source operand is needed sooner than it can be forwarded. It also tracks a multi-cycle mult/div unit and stalls HI/LO-dependent instructions while that unit is busy. It sits beside the D-stage decoder; `stall` freezes PC/IF-ID and bubbles ID-EX.

---
 rtl/hazard_pkg.sv | 11 +
 rtl/md_busy_counter.sv | 19 +
 rtl/hazard_scoreboard.sv | 48 ++++
 tb/tb_hazard_scoreboard.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg: pipeline timing constants shared by the decoder and the hazard scoreboard
package hazard_pkg;
  localparam int TUSE_BRANCH = 0;
  localparam int TUSE_ALU = 1;
  localparam int TUSE_STORE = 2;
  localparam int TNEW_ALU = 1;
  localparam int TNEW_LOAD = 2;
  localparam int TW_DEF = 2;
  localparam int MULT_LAT = 5;
  localparam int DIV_LAT = 10;
endpackage

// File: rtl/md_busy_counter.sv
// md_busy_counter: busy countdown for the multi-cycle mult/div unit
module md_busy_counter import hazard_pkg::*; #(
  parameter int MULT_LAT = hazard_pkg::MULT_LAT,
  parameter int DIV_LAT = hazard_pkg::DIV_LAT
)(
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic div,
  output logic busy
);
  localparam int CW = $clog2((DIV_LAT > MULT_LAT ? DIV_LAT : MULT_LAT) + 1);
  logic [CW-1:0] cnt;
  always_ff @(posedge clk)
    if (reset) cnt <= '0;
    else if (start) cnt <= div ? CW'(DIV_LAT) : CW'(MULT_LAT);
    else if (cnt != '0) cnt <= cnt - 1'b1;
  assign busy = !reset && cnt != '0;
endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: per-register Tuse/Tnew countdown scoreboard driving the decode-stage stall
module hazard_scoreboard import hazard_pkg::*; #(
  parameter int NREG = 32,
  parameter int AW = 5,
  parameter int TW = TW_DEF,
  parameter int MULT_LAT = hazard_pkg::MULT_LAT,
  parameter int DIV_LAT = hazard_pkg::DIV_LAT
)(
  input  logic          clk,
  input  logic          reset,
  input  logic          d_valid,
  input  logic [AW-1:0] d_rs,
  input  logic [AW-1:0] d_rt,
  input  logic          d_rs_use,
  input  logic          d_rt_use,
  input  logic [TW-1:0] d_tuse_rs,
  input  logic [TW-1:0] d_tuse_rt,
  input  logic [AW-1:0] d_dst,
  input  logic          d_dst_we,
  input  logic [TW-1:0] d_tnew,
  input  logic          d_md,
  input  logic          d_md_start,
  input  logic          d_md_div,
  output logic          stall,
  output logic          md_busy
);
  logic [TW-1:0] cnt [NREG];
  logic rs_haz, rt_haz, md_haz, issue, wr;
  assign rs_haz = d_rs_use && d_rs != '0 && cnt[d_rs] > d_tuse_rs;
  assign rt_haz = d_rt_use && d_rt != '0 && cnt[d_rt] > d_tuse_rt;
  assign md_haz = d_md && md_busy;
  assign stall = d_valid && !reset && (rs_haz || rt_haz || md_haz);
  assign issue = d_valid && !stall && !reset;
  assign wr = issue && d_dst_we && d_dst != '0;
  // a fresh write replaces any older pending countdown on the same register
  always_ff @(posedge clk)
    for (int r = 0; r < NREG; r++)
      if (reset || r == 0) cnt[r] <= '0;
      else if (wr && d_dst == AW'(r)) cnt[r] <= d_tnew;
      else if (cnt[r] != '0) cnt[r] <= cnt[r] - 1'b1;
  md_busy_counter #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) u_md (
    .clk(clk),
    .reset(reset),
    .start(issue && d_md_start),
    .div(d_md_div),
    .busy(md_busy)
  );
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: vector table, mult/div and reset sequences, randomized run against a ready-time model
module tb_hazard_scoreboard;
  typedef struct packed {
    logic v;
    logic [4:0] rs, rt;
    logic ru, tu;
    logic [1:0] trs, trt;
    logic [4:0] dst;
    logic we;
    logic [1:0] tn;
    logic md, ms, mdv;
  } in_t;
  typedef struct packed {
    logic r;
    in_t i;
    logic st, bz;
  } vec_t;

  logic clk = 0;
  logic rst_s = 1;
  in_t cur_in = '0;
  logic stall, md_busy;
  int pass = 0, total = 0;
  int ready [32];
  int md_until, now;

  always #5 clk = ~clk;

  hazard_scoreboard dut (
    .clk(clk), .reset(rst_s), .d_valid(cur_in.v),
    .d_rs(cur_in.rs), .d_rt(cur_in.rt), .d_rs_use(cur_in.ru), .d_rt_use(cur_in.tu),
    .d_tuse_rs(cur_in.trs), .d_tuse_rt(cur_in.trt), .d_dst(cur_in.dst), .d_dst_we(cur_in.we),
    .d_tnew(cur_in.tn), .d_md(cur_in.md), .d_md_start(cur_in.ms), .d_md_div(cur_in.mdv),
    .stall(stall), .md_busy(md_busy)
  );

  function automatic in_t ins(logic v, logic [4:0] rs, logic [4:0] rt, logic ru, logic tu,
                              logic [1:0] trs, logic [1:0] trt, logic [4:0] dst, logic we,
                              logic [1:0] tn, logic md, logic ms, logic mdv);
    return '{v, rs, rt, ru, tu, trs, trt, dst, we, tn, md, ms, mdv};
  endfunction
  function automatic in_t nop(); return ins(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); endfunction
  function automatic in_t lw(logic [4:0] d, logic [4:0] b); return ins(1, b, 0, 1, 0, 1, 0, d, 1, 2, 0, 0, 0); endfunction
  function automatic in_t alu(logic [4:0] d, logic [4:0] s, logic [4:0] t); return ins(1, s, t, 1, 1, 1, 1, d, 1, 1, 0, 0, 0); endfunction
  function automatic in_t beq(logic [4:0] s, logic [4:0] t); return ins(1, s, t, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0); endfunction
  function automatic in_t jr(logic [4:0] s); return ins(1, s, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0); endfunction
  function automatic in_t sw(logic [4:0] b, logic [4:0] d); return ins(1, b, d, 1, 1, 1, 2, 0, 0, 0, 0, 0, 0); endfunction
  function automatic in_t mult(); return ins(1, 1, 2, 1, 1, 1, 1, 0, 0, 0, 1, 1, 0); endfunction
  function automatic in_t dv(); return ins(1, 1, 2, 1, 1, 1, 1, 0, 0, 0, 1, 1, 1); endfunction
  function automatic in_t mflo(logic [4:0] d); return ins(1, 0, 0, 0, 0, 0, 0, d, 1, 1, 1, 0, 0); endfunction
  function automatic in_t inval(in_t x); in_t y = x; y.v = 0; return y; endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s @%0t: got %0d expected %0d", nm, $time, act, exp);
    else pass++;
  endtask

  task automatic step(input logic r, input in_t x);
    @(negedge clk);
    rst_s = r;
    cur_in = x;
    #1;
  endtask

  // model: each register remembers the absolute cycle at which its value becomes forwardable
  function automatic int m_cnt(logic [4:0] r);
    return (r == 0 || ready[r] <= now) ? 0 : ready[r] - now;
  endfunction
  function automatic logic m_busy(logic r);
    return !r && md_until >= now;
  endfunction
  function automatic logic m_stall(logic r, in_t x);
    if (r || !x.v) return 0;
    return (x.ru && m_cnt(x.rs) > int'(x.trs)) || (x.tu && m_cnt(x.rt) > int'(x.trt)) || (x.md && m_busy(r));
  endfunction
  task automatic m_update(input logic r, input in_t x, input logic st);
    if (r) begin
      foreach (ready[k]) ready[k] = 0;
      md_until = -1;
    end else if (x.v && !st) begin
      if (x.we && x.dst != 0) ready[x.dst] = now + 1 + int'(x.tn);
      if (x.ms) md_until = now + (x.mdv ? 10 : 5);
    end
    now++;
  endtask

  function automatic in_t rand_ins();
    logic [4:0] a = 5'($urandom_range(0, 7));
    logic [4:0] b = 5'($urandom_range(0, 7));
    logic [4:0] c = 5'($urandom_range(0, 7));
    case ($urandom_range(0, 8))
      0: return nop();
      1: return lw(a, b);
      2: return alu(a, b, c);
      3: return beq(a, b);
      4: return jr(a);
      5: return sw(a, b);
      6: return mult();
      7: return dv();
      default: return mflo(a);
    endcase
  endfunction

  task automatic md_seq(input string nm, input logic is_div, input int exp_st, input int exp_bz);
    int s = 0, b = 0;
    step(0, is_div ? dv() : mult());
    chk({nm, "_issue"}, stall, 0);
    step(0, nop());
    if (md_busy) b++;
    for (int k = 0; k < 20; k++) begin
      step(0, mflo(3));
      if (md_busy) b++;
      if (!stall) break;
      s++;
    end
    chk({nm, "_stalls"}, s, exp_st);
    chk({nm, "_busy_cycles"}, b, exp_bz);
    chk({nm, "_busy_end"}, md_busy, 0);
  endtask

  initial begin
    vec_t tv[$];
    in_t x;
    logic r, es, held;
    tv.push_back('{1'b1, lw(8, 0), 1'b0, 1'b0});
    tv.push_back('{1'b1, mult(), 1'b0, 1'b0});
    tv.push_back('{1'b0, lw(8, 0), 1'b0, 1'b0});
    tv.push_back('{1'b0, beq(8, 0), 1'b1, 1'b0});
    tv.push_back('{1'b0, beq(8, 0), 1'b1, 1'b0});
    tv.push_back('{1'b0, beq(8, 0), 1'b0, 1'b0});
    tv.push_back('{1'b0, alu(9, 0, 0), 1'b0, 1'b0});
    tv.push_back('{1'b0, alu(10, 9, 9), 1'b0, 1'b0});
    tv.push_back('{1'b0, alu(9, 0, 0), 1'b0, 1'b0});
    tv.push_back('{1'b0, jr(9), 1'b1, 1'b0});
    tv.push_back('{1'b0, jr(9), 1'b0, 1'b0});
    tv.push_back('{1'b0, lw(0, 0), 1'b0, 1'b0});
    tv.push_back('{1'b0, beq(0, 0), 1'b0, 1'b0});
    tv.push_back('{1'b0, lw(8, 0), 1'b0, 1'b0});
    tv.push_back('{1'b0, alu(8, 8, 0), 1'b1, 1'b0});
    tv.push_back('{1'b0, alu(8, 8, 0), 1'b0, 1'b0});
    tv.push_back('{1'b0, beq(8, 0), 1'b1, 1'b0});
    tv.push_back('{1'b0, beq(8, 0), 1'b0, 1'b0});
    tv.push_back('{1'b0, lw(11, 0), 1'b0, 1'b0});
    tv.push_back('{1'b0, sw(0, 11), 1'b0, 1'b0});
    tv.push_back('{1'b0, lw(12, 0), 1'b0, 1'b0});
    tv.push_back('{1'b0, alu(13, 12, 0), 1'b1, 1'b0});
    tv.push_back('{1'b0, alu(13, 12, 0), 1'b0, 1'b0});
    tv.push_back('{1'b0, lw(15, 0), 1'b0, 1'b0});
    tv.push_back('{1'b0, inval(beq(15, 0)), 1'b0, 1'b0});
    tv.push_back('{1'b0, beq(15, 0), 1'b1, 1'b0});
    tv.push_back('{1'b0, beq(15, 0), 1'b0, 1'b0});
    foreach (tv[i]) begin
      step(tv[i].r, tv[i].i);
      chk($sformatf("vec%0d_stall", i), stall, tv[i].st);
      chk($sformatf("vec%0d_busy", i), md_busy, tv[i].bz);
    end

    md_seq("div", 1, 9, 10);
    md_seq("mult", 0, 4, 5);

    step(0, dv());
    chk("rst_div_issue", stall, 0);
    step(0, lw(8, 0));
    chk("rst_lw_issue", stall, 0);
    step(1, beq(8, 0));
    chk("rst_stall", stall, 0);
    chk("rst_busy", md_busy, 0);
    step(0, beq(8, 0));
    chk("post_rst_beq", stall, 0);
    step(0, mflo(3));
    chk("post_rst_mflo", stall, 0);
    chk("post_rst_busy", md_busy, 0);

    now = 0;
    md_until = -1;
    foreach (ready[k]) ready[k] = 0;
    step(1, nop());
    m_update(1, nop(), 0);
    held = 0;
    x = nop();
    repeat (3000) begin
      r = ($urandom_range(0, 59) == 0);
      if (!held) x = rand_ins();
      step(r, x);
      es = m_stall(r, x);
      chk("rnd_stall", stall, es);
      chk("rnd_busy", md_busy, m_busy(r));
      m_update(r, x, es);
      held = es;
    end

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
